// File: rtl/fsm_monitor.sv
// Passive observer of the {i2,i1} -> o Mealy controller link: tracks the set of
// controller states consistent with the observed history, reports lock and mismatches.
module fsm_monitor #(
    parameter int KNOWN_RESET = 1,
    parameter int O_LAT       = 1,
    parameter int LOCK_RUN    = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             obs_valid,
    input  logic             obs_i1,
    input  logic             obs_i2,
    input  logic             obs_o,
    output logic [3:0]       cand_mask,
    output logic             locked,
    output logic [1:0]       state_est,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] RESET_MASK = (KNOWN_RESET != 0) ? 4'b0001 : 4'b1111;
    localparam logic [3:0] RUN_MAX    = 4'(LOCK_RUN);

    logic       al_valid;
    logic [1:0] al_inp;
    logic [3:0] run;
    logic [3:0] nm;
    logic [3:0] run_next;
    logic [2:0] ent;
    logic [1:0] nm_low;

    // Delay the input pair so it lines up with the output bit it produced.
    generate
        if (O_LAT == 0) begin : g_no_pipe
            assign al_valid = obs_valid;
            assign al_inp   = {obs_i2, obs_i1};
        end else begin : g_pipe
            logic [2:0] pipe [O_LAT];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < O_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {obs_valid, obs_i2, obs_i1};
                    for (int i = 1; i < O_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign al_valid = pipe[O_LAT-1][2];
            assign al_inp   = pipe[O_LAT-1][1:0];
        end
    endgenerate

    // Controller protocol: returns {next_state, o} for (state, {i2,i1}).
    function automatic logic [2:0] proto(input logic [1:0] s, input logic [1:0] inp);
        case ({s, inp})
            4'b0000: proto = 3'b000;
            4'b0001: proto = 3'b111;
            4'b0010: proto = 3'b010;
            4'b0011: proto = 3'b100;
            4'b0100: proto = 3'b011;
            4'b0101: proto = 3'b010;
            4'b0110: proto = 3'b101;
            4'b0111: proto = 3'b001;
            4'b1000: proto = 3'b110;
            4'b1001: proto = 3'b101;
            4'b1010: proto = 3'b110;
            4'b1011: proto = 3'b011;
            4'b1100: proto = 3'b001;
            4'b1101: proto = 3'b111;
            4'b1110: proto = 3'b101;
            default: proto = 3'b011;
        endcase
    endfunction

    always_comb begin
        nm  = '0;
        ent = '0;
        for (int s = 0; s < 4; s++) begin
            ent = proto(2'(s), al_inp);
            if (cand_mask[s] && (ent[0] == obs_o)) nm[ent[2:1]] = 1'b1;
        end
        if ($onehot(nm)) run_next = (run == RUN_MAX) ? run : run + 4'd1;
        else             run_next = '0;
        if      (nm[0]) nm_low = 2'd0;
        else if (nm[1]) nm_low = 2'd1;
        else if (nm[2]) nm_low = 2'd2;
        else            nm_low = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_mask <= RESET_MASK;
            locked    <= 1'b0;
            state_est <= 2'd0;
            mismatch  <= 1'b0;
            err_count <= '0;
            run       <= '0;
        end else if (al_valid) begin
            if (nm == 4'b0000) begin
                // No candidate explains the observation: count it and resync.
                mismatch  <= 1'b1;
                if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
                cand_mask <= 4'b1111;
                run       <= '0;
                locked    <= 1'b0;
                state_est <= 2'd0;
            end else begin
                mismatch  <= 1'b0;
                cand_mask <= nm;
                run       <= run_next;
                locked    <= (run_next == RUN_MAX);
                state_est <= (run_next == RUN_MAX) ? nm_low : 2'd0;
            end
        end else begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_monitor.sv
// Directed bench for fsm_monitor: vector table on a known-reset instance plus
// hand sequences for unknown reset, output latency, saturation and idle hold.
module tb_fsm_monitor;

    logic clk = 1'b0;
    logic reset;
    logic obs_valid, obs_i1, obs_i2, obs_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Instance a: KNOWN_RESET=1, O_LAT=0
    logic [3:0] a_mask; logic a_locked; logic [1:0] a_est; logic a_mism; logic [7:0] a_err;
    fsm_monitor #(.KNOWN_RESET(1), .O_LAT(0), .LOCK_RUN(2), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_i1(obs_i1), .obs_i2(obs_i2),
        .obs_o(obs_o), .cand_mask(a_mask), .locked(a_locked), .state_est(a_est),
        .mismatch(a_mism), .err_count(a_err));

    // Instance b: KNOWN_RESET=0, O_LAT=0
    logic [3:0] b_mask; logic b_locked; logic [1:0] b_est; logic b_mism; logic [7:0] b_err;
    fsm_monitor #(.KNOWN_RESET(0), .O_LAT(0), .LOCK_RUN(2), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_i1(obs_i1), .obs_i2(obs_i2),
        .obs_o(obs_o), .cand_mask(b_mask), .locked(b_locked), .state_est(b_est),
        .mismatch(b_mism), .err_count(b_err));

    // Instance l: KNOWN_RESET=1, O_LAT=1
    logic [3:0] l_mask; logic l_locked; logic [1:0] l_est; logic l_mism; logic [7:0] l_err;
    fsm_monitor #(.KNOWN_RESET(1), .O_LAT(1), .LOCK_RUN(2), .CNT_W(8)) u_l (
        .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_i1(obs_i1), .obs_i2(obs_i2),
        .obs_o(obs_o), .cand_mask(l_mask), .locked(l_locked), .state_est(l_est),
        .mismatch(l_mism), .err_count(l_err));

    // Instance c: CNT_W=4 for saturation
    logic [3:0] c_mask; logic c_locked; logic [1:0] c_est; logic c_mism; logic [3:0] c_err;
    fsm_monitor #(.KNOWN_RESET(1), .O_LAT(0), .LOCK_RUN(2), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_i1(obs_i1), .obs_i2(obs_i2),
        .obs_o(obs_o), .cand_mask(c_mask), .locked(c_locked), .state_est(c_est),
        .mismatch(c_mism), .err_count(c_err));

    typedef struct packed {
        logic       v;
        logic       i2;
        logic       i1;
        logic       o;
        logic [3:0] mask;
        logic       locked;
        logic [1:0] est;
        logic       mism;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; obs_valid = 1'b0; obs_i1 = 1'b0; obs_i2 = 1'b0; obs_o = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input logic v, input logic i2, input logic i1, input logic o);
        obs_valid = v; obs_i2 = i2; obs_i1 = i1; obs_o = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 v     i2    i1    o     mask     lk    est   mm    err
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b1, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 8'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 2'd0, 1'b0, 8'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0, 8'd2};

        // Reset values
        do_reset();
        check("rst_a_mask", a_mask, 4'b0001);
        check("rst_a_locked", a_locked, 1'b0);
        check("rst_a_est", a_est, 2'd0);
        check("rst_a_mism", a_mism, 1'b0);
        check("rst_a_err", a_err, 8'd0);
        check("rst_b_mask", b_mask, 4'b1111);

        // Vector table on the known-reset instance
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].i2, vecs[i].i1, vecs[i].o);
            check($sformatf("vec%0d_mask", i), a_mask, vecs[i].mask);
            check($sformatf("vec%0d_locked", i), a_locked, vecs[i].locked);
            check($sformatf("vec%0d_est", i), a_est, vecs[i].est);
            check($sformatf("vec%0d_mism", i), a_mism, vecs[i].mism);
            check($sformatf("vec%0d_err", i), a_err, vecs[i].err);
        end

        // Unknown reset state
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("unk_mask1", b_mask, 4'b0010);
        check("unk_locked1", b_locked, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("unk_mask2", b_mask, 4'b0010);
        check("unk_locked2", b_locked, 1'b1);
        check("unk_est2", b_est, 2'd1);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("unk_mask_pair", b_mask, 4'b0011);
        check("unk_locked_pair", b_locked, 1'b0);

        // Output latency of one cycle
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("lat_mask_n", l_mask, 4'b0001);
        check("lat_mism_n", l_mism, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lat_mask_n1", l_mask, 4'b1000);
        check("lat_mism_n1", l_mism, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_bad_mism", l_mism, 1'b1);
        check("lat_bad_err", l_err, 8'd1);
        check("lat_bad_mask", l_mask, 4'b1111);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_bad_pulse", l_mism, 1'b0);

        // Idle cycles hold everything
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check($sformatf("hold%0d_mask", k), a_mask, 4'b0100);
            check($sformatf("hold%0d_locked", k), a_locked, 1'b1);
            check($sformatf("hold%0d_est", k), a_est, 2'd2);
            check($sformatf("hold%0d_mism", k), a_mism, 1'b0);
            check($sformatf("hold%0d_err", k), a_err, 8'd0);
        end

        // Error counter saturation with CNT_W=4
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'd1);
        check("sat_mism1", c_mism, 1'b1);
        check("sat_err1", c_err, 4'(exp_q.pop_front()));
        for (int k = 2; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("sat%0d_narrow", k), c_mask, 4'b0010);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_q.push_back((k > 15) ? 8'd15 : 8'(k));
            check($sformatf("sat%0d_mism", k), c_mism, 1'b1);
            check($sformatf("sat%0d_err", k), c_err, 4'(exp_q.pop_front()));
        end

        // Reset wins over a simultaneous valid step
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("rstv_mask", c_mask, 4'b0001);
        check("rstv_err", c_err, 4'd0);
        check("rstv_mism", c_mism, 1'b0);
        check("rstv_locked", c_locked, 1'b0);
        check("rstv_est", c_est, 2'd0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rstv_after_mask", c_mask, 4'b0001);
        check("rstv_after_lat_mask", l_mask, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fsm_monitor.md
Name: fsm_monitor

Overview:
- Passive receiver-side checker for the 2-input, 1-output Mealy controller stream {i2,i1} -> o.
- Observes the input pair and output bit on the link and tracks the set of controller states consistent with the history.
- Reports lock, the state estimate, and protocol mismatches; saturates an error count.
- Sits beside the controller in integration and in benches as a self-checking observer. It never drives the link.

Parameters:
- KNOWN_RESET, 1: 1 = controller starts in state 2'b00 after reset (mask 4'b0001); 0 = start state unknown (mask 4'b1111).
- O_LAT, 1: cycles by which obs_o trails its obs_i1/obs_i2 pair; legal values 0..3.
- LOCK_RUN, 2: consecutive one-hot-mask steps required before locked asserts; legal values 1..15.
- CNT_W, 8: width of err_count.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- obs_valid, input, 1: current obs_i1/obs_i2 pair is a real controller step.
- obs_i1, input, 1: observed i1.
- obs_i2, input, 1: observed i2.
- obs_o, input, 1: observed controller output, arriving O_LAT cycles after its input pair.
- cand_mask, output, 4: bit s set = controller may be in state s.
- locked, output, 1: state uniquely known for LOCK_RUN steps.
- state_est, output, 2: lowest set index of cand_mask when locked, else 2'b00.
- mismatch, output, 1: one-cycle pulse; the observation was inconsistent with every candidate state.
- err_count, output, CNT_W: saturating mismatch count.

Behaviour:
- Protocol table, inp={i2,i1}, entries are state: inp->next/o.
  - 00: 00->00/0, 01->11/1, 10->01/0, 11->10/0
  - 01: 00->01/1, 01->01/0, 10->10/1, 11->00/1
  - 10: 00->11/0, 01->10/1, 10->11/0, 11->01/1
  - 11: 00->00/1, 01->11/1, 10->10/1, 11->01/1
- Alignment: obs_valid, obs_i2 and obs_i1 pass through an O_LAT-deep shift register (zero depth when O_LAT=0). An aligned step is the delayed valid/inp together with the current obs_o.
- Reset (synchronous, all outputs registered):
  - cand_mask = 4'b0001 if KNOWN_RESET, else 4'b1111.
  - locked=0, state_est=0, mismatch=0, err_count=0, run counter=0, alignment pipe cleared to valid=0.
- Step update: nm = OR over each s in cand_mask where table(s,inp).o == obs_o of onehot(table(s,inp).next).
  - nm != 0: cand_mask<=nm, mismatch<=0.
  - nm == 0: mismatch<=1, err_count<=err_count+1 saturating at all-ones, cand_mask<=4'b1111 (resync), run<=0, locked<=0.
- Run counter:
  - Increments, saturating at LOCK_RUN, on each step whose nm is one-hot. Clears on a step whose nm is not one-hot.
  - locked<=1 when run reaches LOCK_RUN.
  - With KNOWN_RESET=1, the reset mask counts as one-hot but run still starts at 0.
- No aligned step (delayed valid=0): all state holds and mismatch<=0.
- Latency: outputs reflect an aligned step on the next clock edge.
- reset wins over any simultaneous step. Reset mid-stream discards in-flight pipe entries.

Test Plan:
- KNOWN_RESET=1, O_LAT=0, steps inp=01/o=1 then inp=10/o=1 -> cand_mask 1000 then 0100; locked=1 after the 2nd step; state_est=10; mismatch never set.
- KNOWN_RESET=1, O_LAT=0, step inp=01/o=1 then inp=00/o=0 -> 2nd step mismatch pulses 1 cycle, err_count=1, cand_mask=1111, locked=0.
- KNOWN_RESET=0, O_LAT=0, inp=01/o=0 -> cand_mask=0010. Then inp=01/o=0 -> locked=1, state_est=01. Separately, inp=00/o=1 from 1111 -> mask 0011, locked stays 0.
- O_LAT=1, KNOWN_RESET=1: drive inp=01 in cycle n and o=1 in cycle n+1 -> cand_mask=1000 after edge n+1. Same sequence with o=0 -> mismatch.
- CNT_W=4, twenty forced mismatches -> err_count stops at 15. Then assert reset with obs_valid=1 -> all outputs return to reset values and no step is applied.
- obs_valid low for 10 cycles between steps -> cand_mask, locked and err_count held, mismatch stays 0.
